// File: rtl/sccb_master_ctrl.sv
// SCCB master controller: runs one 3-phase write or 2+2-phase read per command.
// SIO_C/SIO_D timing is built from quarters of QTR_CYC sys_clk cycles.
// Optional build macro SCCB_ACK_CHECK_EN: samples the 9th bit of master-sent
// phases and aborts to STOP with rsp_err_o=1 when the slave leaves it high.
module sccb_master_ctrl #(
    parameter int unsigned QTR_CYC = 313
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_rw_i,
    input  logic [7:0] cmd_id_i,
    input  logic [7:0] cmd_sub_i,
    input  logic [7:0] cmd_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_err_o,
    output logic       busy_o,
    output logic       sio_c_o,
    output logic       sio_d_o,
    output logic       sio_d_oe_o,
    input  logic       sio_d_i
);
    localparam int unsigned CW = $clog2(QTR_CYC);

    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [3:0]      bit_q, bit_d;
    logic [1:0]      phase_q, phase_d;
    logic            pass_q, pass_d;
    logic            rw_q, rw_d;
    logic [6:0]      id_q, id_d;
    logic [7:0]      sub_q, sub_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      shift_q, shift_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            sio_c_q, sio_c_d;
    logic            sio_d_q, sio_d_d;
    logic            sio_oe_q, sio_oe_d;
`ifdef SCCB_ACK_CHECK_EN
    logic            ack_err_q, ack_err_d;
`endif

    logic            qtr_end;
    logic            last_phase;
    logic            rd_byte;
    logic            rd_byte_n;
    logic            sample;
    logic            abort;
    logic [7:0]      tx_byte;
    logic            id_lsb_unused;

    assign id_lsb_unused = cmd_id_i[0];

    // Next-state, counters, capture and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        qtr_d       = qtr_q;
        bit_d       = bit_q;
        phase_d     = phase_q;
        pass_d      = pass_q;
        rw_d        = rw_q;
        id_d        = id_q;
        sub_d       = sub_q;
        wdata_d     = wdata_q;
        shift_d     = shift_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef SCCB_ACK_CHECK_EN
        ack_err_d   = ack_err_q;
        abort       = ack_err_q;
`else
        abort       = 1'b0;
`endif
        qtr_end    = (cyc_q == CW'(QTR_CYC - 1));
        rd_byte    = pass_q && (phase_q == 2'd1);
        last_phase = pass_q ? (phase_q == 2'd1)
                            : (rw_q ? (phase_q == 2'd1) : (phase_q == 2'd2));
        sample     = (state_q == S_BIT) && (qtr_q == 2'd2) && (cyc_q == '0);

        // Read data is captured on the SIO_C rising (Q2 entry) cycle.
        if (sample && rd_byte && (bit_q != 4'd0)) begin
            shift_d = {shift_q[6:0], sio_d_i};
        end
`ifdef SCCB_ACK_CHECK_EN
        if (sample && !rd_byte && (bit_q == 4'd0) && sio_d_i) begin
            ack_err_d = 1'b1;
        end
`endif

        if (state_q == S_IDLE) begin
            cyc_d = '0;
        end else begin
            cyc_d = qtr_end ? '0 : cyc_q + CW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    state_d = S_START;
                    qtr_d   = 2'd0;
                    phase_d = 2'd0;
                    pass_d  = 1'b0;
                    rw_d    = cmd_rw_i;
                    id_d    = cmd_id_i[7:1];
                    sub_d   = cmd_sub_i;
                    wdata_d = cmd_wdata_i;
                    shift_d = 8'h00;
`ifdef SCCB_ACK_CHECK_EN
                    ack_err_d = 1'b0;
`endif
                end
            end
            S_START: begin
                if (qtr_end) begin
                    if (qtr_q == 2'd1) begin
                        state_d = S_BIT;
                        qtr_d   = 2'd0;
                        bit_d   = 4'd8;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            S_BIT: begin
                if (qtr_end) begin
                    if (qtr_q == 2'd3) begin
                        qtr_d = 2'd0;
                        if (bit_q == 4'd0) begin
                            if (last_phase || abort) begin
                                state_d = S_STOP;
                            end else begin
                                phase_d = phase_q + 2'd1;
                                bit_d   = 4'd8;
                            end
                        end else begin
                            bit_d = bit_q - 4'd1;
                        end
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            S_STOP: begin
                if (qtr_end) begin
                    if (qtr_q == 2'd2) begin
                        qtr_d = 2'd0;
                        if (rw_q && !pass_q && !abort) begin
                            state_d = S_GAP;
                        end else begin
                            state_d     = S_IDLE;
                            rsp_valid_d = 1'b1;
                            rsp_rdata_d = rw_q ? shift_q : 8'h00;
                            rsp_err_d   = abort;
                        end
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            S_GAP: begin
                if (qtr_end) begin
                    if (qtr_q == 2'd3) begin
                        state_d = S_START;
                        qtr_d   = 2'd0;
                        pass_d  = 1'b1;
                        phase_d = 2'd0;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line levels are decoded from the next state so they align with state_q.
        rd_byte_n = pass_d && (phase_d == 2'd1);
        case (phase_d)
            2'd0:    tx_byte = {id_d, pass_d};
            2'd1:    tx_byte = sub_d;
            default: tx_byte = wdata_d;
        endcase

        sio_c_d  = 1'b1;
        sio_d_d  = 1'b1;
        sio_oe_d = 1'b1;
        case (state_d)
            S_START: begin
                sio_d_d = 1'b0;
                sio_c_d = (qtr_d == 2'd0);
            end
            S_BIT: begin
                sio_c_d = qtr_d[1];
                if (bit_d == 4'd0) begin
                    sio_oe_d = rd_byte_n;
                end else if (rd_byte_n) begin
                    sio_oe_d = 1'b0;
                end else begin
                    sio_d_d = tx_byte[3'(bit_d - 4'd1)];
                end
            end
            S_STOP: begin
                sio_c_d = (qtr_d != 2'd0);
                sio_d_d = (qtr_d == 2'd2);
            end
            default: ;
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            qtr_q       <= 2'd0;
            bit_q       <= 4'd0;
            phase_q     <= 2'd0;
            pass_q      <= 1'b0;
            rw_q        <= 1'b0;
            id_q        <= 7'd0;
            sub_q       <= 8'h00;
            wdata_q     <= 8'h00;
            shift_q     <= 8'h00;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
            sio_c_q     <= 1'b1;
            sio_d_q     <= 1'b1;
            sio_oe_q    <= 1'b1;
`ifdef SCCB_ACK_CHECK_EN
            ack_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            phase_q     <= phase_d;
            pass_q      <= pass_d;
            rw_q        <= rw_d;
            id_q        <= id_d;
            sub_q       <= sub_d;
            wdata_q     <= wdata_d;
            shift_q     <= shift_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            sio_c_q     <= sio_c_d;
            sio_d_q     <= sio_d_d;
            sio_oe_q    <= sio_oe_d;
`ifdef SCCB_ACK_CHECK_EN
            ack_err_q   <= ack_err_d;
`endif
        end
    end

    assign cmd_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign sio_c_o     = sio_c_q;
    assign sio_d_o     = sio_d_q;
    assign sio_d_oe_o  = sio_oe_q;

endmodule
